// File: rtl/jk_bank_driver.sv
// Drives the J/K inputs of an external N-bit JK flop bank to a requested state, verifying the
// fed-back Q and retrying a bounded number of times before latching an error.
module jk_bank_driver #(
  parameter int unsigned N          = 4,
  parameter int unsigned MAX_RETRY  = 2,
  parameter bit          USE_TOGGLE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [N-1:0] tgt_data,
  input  logic [N-1:0] q_fb,
  input  logic         clr_err,
  output logic [N-1:0] j,
  output logic [N-1:0] k,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] err_mask
);

  localparam logic [3:0] MaxRetry = 4'(MAX_RETRY);

  typedef enum logic [2:0] {StClr, StCheck, StIdle, StDrive, StError} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] j_q, j_d, k_q, k_d;
  logic [N-1:0] tgt_q, tgt_d;
  logic [3:0]   retry_q, retry_d;
  logic         ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] chk_j, chk_k, acc_j, acc_k;

  // Returns {J, K}; unchanged bits always get J=K=0.
  function automatic logic [2*N-1:0] excite(input logic [N-1:0] q, input logic [N-1:0] t);
    logic [N-1:0] chg;
    chg = q ^ t;
    if (USE_TOGGLE) begin
      return {chg, chg};
    end
    return {chg & t, chg & ~t};
  endfunction

  assign {chk_j, chk_k} = excite(q_fb, tgt_q);
  assign {acc_j, acc_k} = excite(q_fb, tgt_data);

  always_comb begin
    state_d = state_q;
    j_d     = '0;
    k_d     = '0;
    tgt_d   = tgt_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    mask_d  = mask_q;
    unique case (state_q)
      StClr: begin
        state_d = StCheck;
      end
      StCheck: begin
        if (q_fb == tgt_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
          retry_d = '0;
        end else if (retry_q < MaxRetry) begin
          state_d = StDrive;
          retry_d = retry_q + 4'd1;
          j_d     = chk_j;
          k_d     = chk_k;
        end else begin
          state_d = StError;
          mask_d  = q_fb ^ tgt_q;
        end
      end
      StIdle: begin
        if (tgt_valid) begin
          state_d = StDrive;
          tgt_d   = tgt_data;
          retry_d = '0;
          j_d     = acc_j;
          k_d     = acc_k;
        end
      end
      StDrive: begin
        state_d = StCheck;
      end
      StError: begin
        if (clr_err) begin
          state_d = StClr;
          mask_d  = '0;
          retry_d = '0;
          tgt_d   = '0;
          k_d     = '1;
        end
      end
      default: begin
        state_d = StClr;
        k_d     = '1;
      end
    endcase
    // Status outputs are registered copies of what the next state implies.
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle) && (state_d != StError);
    err_d   = (state_d == StError);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClr;
      j_q     <= '0;
      k_q     <= '1;
      tgt_q   <= '0;
      retry_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  assign tgt_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = mask_q;
  assign j         = j_q;
  assign k         = k_q;

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Controller that drives the J/K inputs of an external bank of N JK flip-flops. It moves the bank to a requested N-bit target state.
- Accepts targets over a valid/ready handshake. Computes per-bit J/K excitation from the bank's fed-back Q and pulses it for one clock.
- Verifies the bank reached the target, retrying a bounded number of times. Latches an error with a per-bit mismatch mask if the bank never converges.
- Used wherever the design keeps state in discrete JK flop banks instead of D registers.

Parameters:
- N, 4: width of the flop bank (number of JK flops driven).
- MAX_RETRY, 2: extra drive attempts after the first mismatch before entering ERROR (0..15).
- USE_TOGGLE, 0: 0 = set/reset encoding for changing bits (J=1,K=0 or J=0,K=1); 1 = toggle encoding (J=1,K=1) for changing bits.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: reset, synchronous, active-high.
- tgt_valid, input, 1: target word valid.
- tgt_ready, output, 1: block idle and able to accept a target.
- tgt_data, input, N: requested bank state.
- q_fb, input, N: current Q outputs of the external JK bank.
- clr_err, input, 1: leaves ERROR and re-clears the bank.
- j, output, N: registered J drive to the bank.
- k, output, N: registered K drive to the bank.
- busy, output, 1: high in every state except IDLE and ERROR.
- done, output, 1: one-cycle pulse, bank verified equal to target.
- err, output, 1: sticky error flag, high only in ERROR.
- err_mask, output, N: q_fb XOR target captured on entry to ERROR.

Behaviour:
- States: CLR, CHECK, IDLE, DRIVE, ERROR. All outputs are registered.
- Reset (rst=1 at an edge, any state, mid-operation included; rst wins over every other input):
  - state=CLR; j=0; k={N{1}}; target register=0; retry_cnt=0.
  - tgt_ready=0; busy=1; done=0; err=0; err_mask=0.
- CLR: k=all ones is presented for one cycle, so the bank clears to 0 at the edge that leaves CLR. Next state CHECK, with j=k=0 loaded.
- CHECK: compare q_fb with the target register during this cycle. j=k=0.
  - Match: next state IDLE; done=1 for the following cycle; retry_cnt<=0.
  - Mismatch and retry_cnt<MAX_RETRY: retry_cnt++; load j/k from the excitation table using the current q_fb; next state DRIVE.
  - Mismatch and retry_cnt==MAX_RETRY: next state ERROR; err<=1; err_mask<=q_fb^target.
- IDLE: tgt_ready=1, busy=0, j=k=0.
  - On tgt_valid&tgt_ready at an edge: capture tgt_data; load j/k from q_fb and tgt_data; next state DRIVE.
  - In any other state tgt_ready=0 and tgt_valid is ignored; the source must hold its data.
- DRIVE: j/k are held for exactly one cycle. The bank samples them at the edge leaving DRIVE. Next state CHECK, with j=k=0 loaded.
- Excitation table, per bit (current q, target t):
  - q=0, t=0: J=0, K=0.
  - q=1, t=1: J=0, K=0.
  - q=0, t=1: J=1, K=0 (USE_TOGGLE=0) or J=1, K=1 (USE_TOGGLE=1).
  - q=1, t=0: J=0, K=1 (USE_TOGGLE=0) or J=1, K=1 (USE_TOGGLE=1).
  - Never J=K=1 on an unchanged bit.
- Latency: accept at edge E0 → DRIVE in cycle after E0 → CHECK next cycle → done high in the third cycle after E0. tgt_ready rises in the same cycle as done.
- Target equal to q_fb: DRIVE still occurs with j=k=0, giving the same 3-cycle latency.
- ERROR: j=k=0; tgt_ready=0; busy=0; err and err_mask held.
  - clr_err=1 at an edge: err<=0, err_mask<=0, retry_cnt<=0, target<=0, k<={N{1}}, next state CLR.
  - clr_err outside ERROR is ignored.
- done is never asserted in the same cycle as err.
- retry_cnt is 4 bits. It resets on every accept and on every CHECK match.

Test Plan:
- Reset release with a bank model holding 4'b1010: k=4'b1111 during rst and for 1 cycle after → CHECK sees 0000 → IDLE, done pulse, tgt_ready=1.
- USE_TOGGLE=0, bank 0000, target 4'b0110: DRIVE cycle shows j=0110, k=0000; done 3 cycles after accept; q_fb=0110.
- Bank 0110, target 4'b1100, USE_TOGGLE=0: j=1000, k=0010. With USE_TOGGLE=1: j=k=1010. Both end with q_fb=1100.
- Bank model with bit 2 stuck at 0, target 4'b0100, MAX_RETRY=2: exactly 3 DRIVE cycles → err=1, err_mask=0100, done never pulses. clr_err → CLR → IDLE.
- tgt_valid held high with changing data while busy: no extra accepts. Next accept only in the cycle done=1 and tgt_ready=1, capturing the data present at that edge.
- rst asserted during DRIVE (j=0001): next cycle j=0, k=1111, state CLR, done=0, err=0. Recovery as in scenario 1.
